// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and round-robin scan helper for mux_arb_nx1
//
// Purpose : mode encoding, scan limits and the modulo priority scan used by
//           the round-robin arbiter.
// Contents: mux_mode_e, MAX_CH, IDX_W, rr_pick_t, rr_pick()
package mux_arb_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_e;

    // The helper is written once for the widest supported mux; callers
    // zero-extend their vectors and pass their real channel count.
    localparam int MAX_CH = 64;
    localparam int IDX_W  = 6;
    localparam int IDX_W1 = IDX_W + 1;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First valid channel scanning ptr+1, ptr+2, ... modulo n_ch.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_CH-1:0] valid,
        input logic [IDX_W-1:0]  ptr,
        input logic [IDX_W:0]    n_ch
    );
        rr_pick_t       pick;
        logic [IDX_W:0] idx;
        pick = '0;
        // Walk from the farthest offset back to the nearest so that the
        // nearest valid channel is the one left in pick.
        for (int k = MAX_CH; k >= 1; k--) begin
            if (k <= int'(n_ch)) begin
                idx = {1'b0, ptr} + IDX_W1'(k);
                if (idx >= n_ch) begin
                    idx = idx - n_ch;
                end
                if (valid[idx[IDX_W-1:0]]) begin
                    pick.found = 1'b1;
                    pick.idx   = idx[IDX_W-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - combinational round-robin grant for N_CH requesters
//
// Purpose: picks the first valid channel after ptr (modulo N_CH).
// Ports  : valid [N_CH]  in   per-channel request
//          ptr   [SEL_W] in   last granted channel
//          grant [N_CH]  out  one-hot grant (all zero when nothing valid)
//          idx   [SEL_W] out  index of the granted channel
//          found         out  a grant was made
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int  N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  valid,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    rr_pick_t pick;

    always_comb begin
        pick  = rr_pick(MAX_CH'(valid), IDX_W'(ptr), IDX_W1'(N_CH));
        found = pick.found;
        idx   = pick.idx[SEL_W-1:0];
        grant = '0;
        for (int i = 0; i < N_CH; i++) begin
            grant[i] = pick.found && (pick.idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/mux_arb_nx1.sv
// rtl/mux_arb_nx1.sv - N-to-1 streaming word mux with select / round-robin modes
//
// Purpose: selects one of N_CH valid/ready input channels per cycle into a
//          registered output; one-cycle latency, full throughput.
// Ports  : clk, rst_n (async active-low)
//          mode                 0 = explicit select, 1 = round-robin
//          sel       [SEL_W]    channel used in select mode
//          in_valid  [N_CH]     per-channel valid
//          in_data   [N_CH*DATA_W] channel i at [i*DATA_W +: DATA_W]
//          in_ready  [N_CH]     per-channel accept, at most one bit high
//          out_valid/out_data/out_ch  registered word and its source channel
//          out_ready            consumer accept
// Config : MUX_LAST_LOCK_EN adds in_last [N_CH] / out_last and holds the grant
//          on a channel until it sends a word marked last.
module mux_arb_nx1
    import mux_arb_pkg::*;
#(
    parameter int  N_CH   = 4,
    parameter int  DATA_W = 32,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
`ifdef MUX_LAST_LOCK_EN
    input  logic [N_CH-1:0]          in_last,
    output logic                     out_last,
`endif
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);

    mux_mode_e        mode_e;
    logic [SEL_W-1:0] rr_ptr;
    logic [N_CH-1:0]  rr_grant;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_found;

    logic             lock;
    logic [SEL_W-1:0] lock_ch;

    logic             load_en;
    logic             xfer_in;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_any;
    logic [DATA_W-1:0] grant_data;

    assign mode_e = mux_mode_e'(mode);

    mux_rr_arbiter #(
        .N_CH (N_CH)
    ) u_rr (
        .valid (in_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // Register can take a new word when empty or when its word leaves now.
    assign load_en = !out_valid || out_ready;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (lock) begin
            for (int i = 0; i < N_CH; i++) begin
                if (lock_ch == SEL_W'(i) && in_valid[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = lock_ch;
                    grant_any = 1'b1;
                end
            end
        end else if (mode_e == MODE_RR) begin
            grant     = rr_grant;
            grant_idx = rr_idx;
            grant_any = rr_found;
        end else begin
            // An out-of-range sel matches no channel and so grants nothing.
            for (int i = 0; i < N_CH; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = sel;
                    grant_any = 1'b1;
                end
            end
        end
    end

    // Grant is one-hot, so an AND-OR mux picks the word.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                grant_data = grant_data | in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_ready = grant & {N_CH{load_en}};
    assign xfer_in  = grant_any && load_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SEL_W'(N_CH - 1);
        end else begin
            if (xfer_in) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Select-mode traffic leaves the round-robin position untouched.
            if (xfer_in && mode_e == MODE_RR) begin
                rr_ptr <= grant_idx;
            end
        end
    end

`ifdef MUX_LAST_LOCK_EN
    logic grant_last;

    assign grant_last = |(grant & in_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock     <= 1'b0;
            lock_ch  <= '0;
            out_last <= 1'b0;
        end else if (xfer_in) begin
            lock     <= !grant_last;
            lock_ch  <= grant_idx;
            out_last <= grant_last;
        end
    end
`else
    assign lock    = 1'b0;
    assign lock_ch = '0;
`endif

endmodule
